// File: rtl/motor_pkg.sv
// Shared types and helpers for the motor command ramp: FSM states, field widths
// and the saturating step used for every magnitude update.
package motor_pkg;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      BRAKE = 2'd1,
      DEAD  = 2'd2
   } state_t;

   localparam int MAG_W   = 7;
   localparam int DIR_BIT = 7;

   // Moves cur toward tgt by at most step and never overshoots. The add cannot
   // wrap because it is only taken when cur + step < tgt <= 127.
   function automatic logic [MAG_W-1:0] sat_step(input logic [MAG_W-1:0] cur,
                                                 input logic [MAG_W-1:0] tgt,
                                                 input logic [MAG_W-1:0] step);
      logic [MAG_W-1:0] res;
      if (cur < tgt) begin
         res = ((tgt - cur) <= step) ? tgt : cur + step;
      end else begin
         res = ((cur - tgt) <= step) ? tgt : cur - step;
      end
      return res;
   endfunction

endpackage

// File: rtl/ramp_tick_gen.sv
// Free-running prescaler: pulses tick for one clk every RAMP_DIV cycles.
// Commands never restart it, so slew timing stays on a fixed grid.
module ramp_tick_gen #(
   parameter int RAMP_DIV = 1000
) (
   input  logic clk,
   input  logic reset,
   output logic tick
);

   localparam int CW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(RAMP_DIV - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   always_comb begin
      tick  = (cnt_q == LAST);
      cnt_d = tick ? '0 : cnt_q + CW'(1);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/motor_cmd_ramp.sv
// Slews signed speed commands toward their target, braking to zero and holding a
// dead time before any direction reversal. Output is {dir, mag} for the PWM stage.
module motor_cmd_ramp
   import motor_pkg::*;
#(
   parameter int RAMP_DIV   = 1000,
   parameter int STEP       = 1,
   parameter int DEAD_TICKS = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] cmd_val,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic       estop,
   output logic [7:0] pwm_val,
   output logic       at_target,
   output logic       busy,
   output state_t     state_dbg
);

   // Handshake: a command transfers on a rising clk edge where cmd_valid and
   // cmd_ready are both high; the source holds cmd_val stable until then.

   localparam int DW = $clog2(DEAD_TICKS + 1);
   localparam logic [MAG_W-1:0] STEP_M    = MAG_W'(STEP);
   localparam logic [DW-1:0]    DEAD_INIT = DW'(DEAD_TICKS);

   state_t           state_q, state_d;
   logic             dir_q, dir_d;
   logic [MAG_W-1:0] mag_q, mag_d;
   logic             tgt_dir_q, tgt_dir_d;
   logic [MAG_W-1:0] tgt_mag_q, tgt_mag_d;
   logic [DW-1:0]    dead_q, dead_d;

   logic             tick;
   logic             accept;
   logic             cmd_dir;
   logic             reversal;
   logic [MAG_W-1:0] brake_mag;

   ramp_tick_gen #(.RAMP_DIV(RAMP_DIV)) u_tick (
      .clk   (clk),
      .reset (reset),
      .tick  (tick)
   );

   assign cmd_ready = (state_q != DEAD) && !estop;
   assign accept    = cmd_valid && cmd_ready;
   assign pwm_val   = {dir_q, mag_q};
   assign busy      = (state_q != RUN);
   assign at_target = (state_q == RUN) && (dir_q == tgt_dir_q) && (mag_q == tgt_mag_q);
   assign state_dbg = state_q;

   always_comb begin
      state_d   = state_q;
      dir_d     = dir_q;
      mag_d     = mag_q;
      tgt_dir_d = tgt_dir_q;
      tgt_mag_d = tgt_mag_q;
      dead_d    = dead_q;

      // A zero-magnitude command keeps the present direction: slow down, never flip.
      cmd_dir   = (cmd_val[MAG_W-1:0] == '0) ? dir_q : cmd_val[DIR_BIT];
      reversal  = (tgt_dir_q != dir_q) && (tgt_mag_q != '0);
      brake_mag = sat_step(mag_q, '0, STEP_M);

      if (estop) begin
         mag_d     = '0;
         tgt_mag_d = '0;
         tgt_dir_d = dir_q;
         dead_d    = '0;
         state_d   = RUN;
      end else begin
         if (tick) begin
            case (state_q)
               RUN: begin
                  if (!reversal) begin
                     mag_d = sat_step(mag_q, tgt_mag_q, STEP_M);
                  end else if (mag_q == '0) begin
                     state_d = DEAD;
                     dead_d  = DEAD_INIT;
                  end else begin
                     state_d = BRAKE;
                     mag_d   = brake_mag;
                  end
               end
               BRAKE: begin
                  mag_d = brake_mag;
                  if (brake_mag == '0) begin
                     state_d = DEAD;
                     dead_d  = DEAD_INIT;
                  end
               end
               DEAD: begin
                  dead_d = dead_q - DW'(1);
                  if (dead_q == DW'(1)) begin
                     dir_d   = tgt_dir_q;
                     state_d = RUN;
                  end
               end
               default: state_d = RUN;
            endcase
         end

         // The tick above already used the old target; the new one lands after it.
         if (accept) begin
            tgt_dir_d = cmd_dir;
            tgt_mag_d = cmd_val[MAG_W-1:0];
            if ((state_q == BRAKE) && (cmd_dir == dir_q)) begin
               state_d = RUN;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= RUN;
         dir_q     <= 1'b0;
         mag_q     <= '0;
         tgt_dir_q <= 1'b0;
         tgt_mag_q <= '0;
         dead_q    <= '0;
      end else begin
         state_q   <= state_d;
         dir_q     <= dir_d;
         mag_q     <= mag_d;
         tgt_dir_q <= tgt_dir_d;
         tgt_mag_q <= tgt_mag_d;
         dead_q    <= dead_d;
      end
   end

endmodule

// File: tb/tb_motor_cmd_ramp.sv
// Bench for motor_cmd_ramp: a per-edge behavioural model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_motor_cmd_ramp;
   import motor_pkg::*;

   localparam int RAMP_DIV   = 4;
   localparam int STEP       = 8;
   localparam int DEAD_TICKS = 2;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] cmd_val;
   logic       cmd_valid;
   logic       cmd_ready;
   logic       estop;
   logic [7:0] pwm_val;
   logic       at_target;
   logic       busy;
   state_t     state_dbg;

   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;

   motor_cmd_ramp #(
      .RAMP_DIV   (RAMP_DIV),
      .STEP       (STEP),
      .DEAD_TICKS (DEAD_TICKS)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .cmd_val   (cmd_val),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .estop     (estop),
      .pwm_val   (pwm_val),
      .at_target (at_target),
      .busy      (busy),
      .state_dbg (state_dbg)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   int m_cnt   = 0;
   int m_mag   = 0;
   int m_tmag  = 0;
   int m_dead  = 0;
   bit m_dir   = 1'b0;
   bit m_tdir  = 1'b0;
   bit m_brake = 1'b0;

   bit m_tk, m_acc, m_ndir, m_old_dir, m_was_brake;
   int m_nmag;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_cnt = 0; m_mag = 0; m_tmag = 0; m_dead = 0;
         m_dir = 1'b0; m_tdir = 1'b0; m_brake = 1'b0;
      end else begin
         m_tk          = (m_cnt == RAMP_DIV - 1);
         m_cnt         = m_tk ? 0 : m_cnt + 1;
         m_acc         = cmd_valid && (m_dead == 0) && !estop;
         m_old_dir     = m_dir;
         m_was_brake   = m_brake;
         if (estop) begin
            m_mag = 0; m_tmag = 0; m_tdir = m_dir; m_brake = 1'b0; m_dead = 0;
         end else begin
            if (m_tk) begin
               if (m_dead > 0) begin
                  m_dead = m_dead - 1;
                  if (m_dead == 0) m_dir = m_tdir;
               end else if (m_brake) begin
                  m_mag = (m_mag > STEP) ? m_mag - STEP : 0;
                  if (m_mag == 0) begin
                     m_brake = 1'b0;
                     m_dead  = DEAD_TICKS;
                  end
               end else if (m_tdir != m_dir && m_tmag != 0) begin
                  if (m_mag == 0) begin
                     m_dead = DEAD_TICKS;
                  end else begin
                     m_brake = 1'b1;
                     m_mag   = (m_mag > STEP) ? m_mag - STEP : 0;
                  end
               end else if (m_mag < m_tmag) begin
                  m_mag = (m_mag + STEP > m_tmag) ? m_tmag : m_mag + STEP;
               end else begin
                  m_mag = (m_mag - STEP < m_tmag) ? m_tmag : m_mag - STEP;
               end
            end
            if (m_acc) begin
               m_nmag = int'(cmd_val[6:0]);
               m_ndir = (m_nmag == 0) ? m_old_dir : cmd_val[7];
               m_tdir = m_ndir;
               m_tmag = m_nmag;
               if (m_was_brake && m_ndir == m_old_dir) begin
                  m_brake = 1'b0;
                  m_dead  = 0;
               end
            end
         end
      end
   end

   // ---------------- check helpers ----------------
   task automatic check8(input string nm, input logic [7:0] act, input logic [7:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at %0t: got %h want %h", nm, $time, act, exp);
      end
   endtask

   task automatic check1(input string nm, input logic act, input logic exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at %0t: got %b want %b", nm, $time, act, exp);
      end
   endtask

   task automatic timeout(input string nm);
      total++;
      bad++;
      $display("FAIL %s at %0t: timed out waiting", nm, $time);
   endtask

   // ---------------- scoreboard compare, every cycle ----------------
   logic [7:0] e_pwm;
   logic       e_busy;
   always @(negedge clk) begin
      if (chk_en) begin
         e_pwm  = {m_dir, 7'(m_mag)};
         e_busy = m_brake || (m_dead > 0);
         check8("cmp_pwm_val", pwm_val, e_pwm);
         check1("cmp_cmd_ready", cmd_ready, (m_dead == 0) && !estop);
         check1("cmp_busy", busy, e_busy);
         check1("cmp_at_target", at_target, !e_busy && (m_dir == m_tdir) && (m_mag == m_tmag));
      end
   end

   // ---------------- driver tasks ----------------
   task automatic send_cmd(input logic [7:0] v);
      bit done;
      done = 1'b0;
      @(negedge clk);
      #2;
      cmd_valid = 1'b1;
      cmd_val   = v;
      for (int n = 0; n < 300 && !done; n++) begin
         #1;
         if (cmd_ready) begin
            @(posedge clk);
            done = 1'b1;
         end else begin
            @(negedge clk);
         end
      end
      if (!done) timeout("send_cmd");
      @(negedge clk);
      #2;
      cmd_valid = 1'b0;
   endtask

   // mode 0: settled at target, 1: in dead time, 2: braking at mag arg, 3: running at mag arg
   task automatic wait_for(input int mode, input int arg, input string nm);
      bit hit;
      hit = 1'b0;
      for (int n = 0; n < 300 && !hit; n++) begin
         @(negedge clk);
         #1;
         case (mode)
            0: hit = !m_brake && m_dead == 0 && m_dir == m_tdir && m_mag == m_tmag;
            1: hit = (m_dead > 0);
            2: hit = m_brake && m_mag == arg;
            default: hit = !m_brake && m_dead == 0 && m_mag == arg;
         endcase
      end
      if (!hit) timeout(nm);
   endtask

   // ---------------- directed scenarios ----------------
   logic [7:0] prev;
   int         changes;

   initial begin
      reset     = 1'b1;
      cmd_valid = 1'b0;
      cmd_val   = 8'h00;
      estop     = 1'b0;
      chk_en    = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      check8("rst_pwm_val", pwm_val, 8'h00);
      check1("rst_cmd_ready", cmd_ready, 1'b1);
      check1("rst_busy", busy, 1'b0);
      check1("rst_at_target", at_target, 1'b1);
      check1("rst_state_run", state_dbg == RUN, 1'b1);
      #1;
      reset = 1'b0;

      // small command clamps to its target on the first tick
      send_cmd(8'h05);
      repeat (RAMP_DIV) @(negedge clk);
      #1;
      check8("clamp_pwm_val", pwm_val, 8'h05);
      check1("clamp_at_target", at_target, 1'b1);
      send_cmd(8'h00);
      wait_for(0, 0, "wait_zero");

      // ramp 0 -> 0x40 in eight visible steps
      send_cmd(8'h40);
      prev    = pwm_val;
      changes = 0;
      for (int n = 0; n < 80; n++) begin
         @(negedge clk);
         #1;
         if (pwm_val !== prev) changes++;
         prev = pwm_val;
         if (!m_brake && m_dead == 0 && m_mag == 64) break;
      end
      check8("ramp_pwm_val", pwm_val, 8'h40);
      check1("ramp_at_target", at_target, 1'b1);
      check1("ramp_step_count", changes == 8, 1'b1);

      // reversal: brake, dead time, then ramp the other way
      send_cmd(8'hA0);
      wait_for(1, 0, "wait_dead");
      check8("dead_pwm_val", pwm_val, 8'h00);
      check1("dead_cmd_ready", cmd_ready, 1'b0);
      check1("dead_busy", busy, 1'b1);
      wait_for(0, 0, "wait_rev_target");
      check8("rev_pwm_val", pwm_val, 8'hA0);
      check1("rev_at_target", at_target, 1'b1);

      // same-direction command during brake cancels the reversal
      send_cmd(8'h40);
      wait_for(0, 0, "wait_fwd_target");
      send_cmd(8'hA0);
      wait_for(2, 32, "wait_brake32");
      send_cmd(8'h30);
      check1("cancel_busy", busy, 1'b0);
      check8("cancel_pwm_val", pwm_val, 8'h20);
      wait_for(0, 0, "wait_cancel_target");
      check8("cancel_final", pwm_val, 8'h30);

      // estop while ramping, with a command offered on the same edge
      send_cmd(8'h00);
      wait_for(0, 0, "wait_zero2");
      send_cmd(8'h40);
      wait_for(3, 24, "wait_mag24");
      #1;
      estop     = 1'b1;
      cmd_valid = 1'b1;
      cmd_val   = 8'h7F;
      @(negedge clk);
      #1;
      check8("estop_pwm_val", pwm_val, 8'h00);
      check1("estop_cmd_ready", cmd_ready, 1'b0);
      estop     = 1'b0;
      cmd_valid = 1'b0;
      @(negedge clk);
      #1;
      check1("estop_at_target", at_target, 1'b1);
      repeat (8) @(negedge clk);
      #1;
      check8("estop_hold", pwm_val, 8'h00);

      // async reset in the middle of a dead time
      send_cmd(8'h90);
      wait_for(1, 0, "wait_dead2");
      reset = 1'b1;
      #1;
      check8("areset_pwm_val", pwm_val, 8'h00);
      check1("areset_cmd_ready", cmd_ready, 1'b1);
      check1("areset_busy", busy, 1'b0);
      @(negedge clk);
      #2;
      reset     = 1'b0;
      cmd_valid = 1'b1;
      cmd_val   = 8'h08;
      @(negedge clk);
      #2;
      cmd_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #1;
      check8("post_reset_pre_tick", pwm_val, 8'h00);
      @(negedge clk);
      #1;
      check8("post_reset_first_tick", pwm_val, 8'h08);

      repeat (4) @(negedge clk);
      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
